// File: rtl/sha_msg_padder.sv
// rtl/sha_msg_padder.sv - byte stream to padded, big-endian SHA message blocks
// Bytes (message, 0x80, zero fill, bit length) are packed into words as they arrive.
module sha_msg_padder #(
   parameter int WORD_BYTES = 4,
   parameter int LEN_W      = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_byte_valid,
   input  logic [7:0]              i_byte_data,
   input  logic                    i_byte_last,
   output logic                    o_byte_ready,
   output logic                    o_word_valid,
   output logic [8*WORD_BYTES-1:0] o_word_data,
   output logic                    o_word_first,
   output logic [3:0]              o_word_idx,
   output logic                    o_word_last,
   input  logic                    i_word_ready
);

   localparam int B      = 16 * WORD_BYTES;
   localparam int L      = LEN_W / 8;
   localparam int BPOS_W = $clog2(B);
   localparam int LANE_W = $clog2(WORD_BYTES);
   localparam int LK_W   = $clog2(L);
   localparam logic [BPOS_W-1:0] LEN_POS = BPOS_W'(B - L);

   typedef enum logic [1:0] {S_DATA, S_PAD80, S_ZERO, S_LEN} state_t;

   state_t                  r_state;
   state_t                  w_state_nx;
   logic [8*WORD_BYTES-9:0] r_asm;
   logic [BPOS_W-1:0]       r_bpos;
   logic [LEN_W-4:0]        r_mcnt;

   logic                    w_lane_last;
   logic                    w_advance;
   logic                    w_consume;
   logic                    w_len_end;
   logic [7:0]              w_src;
   logic [BPOS_W-1:0]       w_bpos_nx;
   logic [LEN_W-1:0]        w_len;
   logic [LK_W-1:0]         w_lk;

   // The completing byte of a word may only land when the output register can take it.
   assign w_lane_last = &r_bpos[LANE_W-1:0];
   assign w_advance   = !w_lane_last || !o_word_valid || i_word_ready;
   assign w_bpos_nx   = r_bpos + 1'b1;
   assign w_len       = {r_mcnt, 3'b000};
   assign w_lk        = ~r_bpos[LK_W-1:0];
   assign w_len_end   = (r_state == S_LEN) && (&r_bpos);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_DATA;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      if (w_consume) begin
         case (r_state)
            S_DATA:          if (i_byte_last) w_state_nx = S_PAD80;
            S_PAD80, S_ZERO: w_state_nx = (w_bpos_nx == LEN_POS) ? S_LEN : S_ZERO;
            S_LEN:           if (&r_bpos) w_state_nx = S_DATA;
            default:         w_state_nx = S_DATA;
         endcase
      end
   end

   // Length bytes go out MSB first: position B-L carries byte L-1 of the length.
   always_comb begin
      o_byte_ready = 1'b0;
      w_consume    = 1'b0;
      w_src        = 8'h00;
      case (r_state)
         S_DATA: begin
            o_byte_ready = !i_rst && w_advance;
            w_consume    = o_byte_ready && i_byte_valid;
            w_src        = i_byte_data;
         end
         S_PAD80: begin
            w_consume = w_advance;
            w_src     = 8'h80;
         end
         S_ZERO: begin
            w_consume = w_advance;
         end
         S_LEN: begin
            w_consume = w_advance;
            w_src     = w_len[{w_lk, 3'b000} +: 8];
         end
         default: begin
            w_consume = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_asm        <= '0;
         r_bpos       <= '0;
         r_mcnt       <= '0;
         o_word_valid <= 1'b0;
         o_word_data  <= '0;
         o_word_first <= 1'b0;
         o_word_idx   <= '0;
         o_word_last  <= 1'b0;
      end else begin
         if (w_consume) begin
            r_asm  <= {r_asm[8*WORD_BYTES-17:0], w_src};
            r_bpos <= w_bpos_nx;
            if (r_state == S_DATA) begin
               r_mcnt <= r_mcnt + 1'b1;
            end else if (w_len_end) begin
               r_mcnt <= '0;
            end
         end
         if (w_consume && w_lane_last) begin
            o_word_valid <= 1'b1;
            o_word_data  <= {r_asm, w_src};
            o_word_idx   <= r_bpos[BPOS_W-1:LANE_W];
            o_word_first <= (r_bpos[BPOS_W-1:LANE_W] == '0);
            o_word_last  <= w_len_end;
         end else if (i_word_ready) begin
            o_word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sha_msg_padder.sv
// tb/tb_sha_msg_padder.sv - randomized self-checking bench for sha_msg_padder
// Two instances (4/64 and 8/128) share stimulus; sel picks the active one.
module tb_sha_msg_padder;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_last;
   logic        word_ready;

   logic        br4, wv4, wf4, wl4;
   logic [31:0] wd4;
   logic [3:0]  wi4;
   logic        br8, wv8, wf8, wl8;
   logic [63:0] wd8;
   logic [3:0]  wi8;

   logic        byte_ready_o, word_valid_o, word_first_o, word_last_o;
   logic [63:0] word_data_o;
   logic [3:0]  word_idx_o;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  q_bytes[$];
   bit          q_last[$];
   logic [63:0] exp_words[$];
   logic [3:0]  exp_idx[$];
   bit          exp_last[$];
   int          pad_total;

   always #5 clk = ~clk;

   sha_msg_padder #(.WORD_BYTES(4), .LEN_W(64)) dut4 (
      .i_clk(clk), .i_rst(rst),
      .i_byte_valid(byte_valid & ~sel), .i_byte_data(byte_data), .i_byte_last(byte_last),
      .o_byte_ready(br4), .o_word_valid(wv4), .o_word_data(wd4), .o_word_first(wf4),
      .o_word_idx(wi4), .o_word_last(wl4), .i_word_ready(word_ready | sel)
   );

   sha_msg_padder #(.WORD_BYTES(8), .LEN_W(128)) dut8 (
      .i_clk(clk), .i_rst(rst),
      .i_byte_valid(byte_valid & sel), .i_byte_data(byte_data), .i_byte_last(byte_last),
      .o_byte_ready(br8), .o_word_valid(wv8), .o_word_data(wd8), .o_word_first(wf8),
      .o_word_idx(wi8), .o_word_last(wl8), .i_word_ready(word_ready | ~sel)
   );

   assign byte_ready_o = sel ? br8 : br4;
   assign word_valid_o = sel ? wv8 : wv4;
   assign word_first_o = sel ? wf8 : wf4;
   assign word_last_o  = sel ? wl8 : wl4;
   assign word_idx_o   = sel ? wi8 : wi4;
   assign word_data_o  = sel ? wd8 : {32'h0, wd4};

   // Reference: pad the whole message as a byte list, then cut it into words.
   task automatic add_msg(input logic [7:0] m[$]);
      int          wb   = sel ? 8 : 4;
      int          lb   = sel ? 16 : 8;
      int          bb   = 16 * wb;
      logic [63:0] bits = 64'(m.size()) * 64'd8;
      logic [7:0]  p[$];
      logic [63:0] w;
      int          nw;
      for (int i = 0; i < m.size(); i++) begin
         q_bytes.push_back(m[i]);
         q_last.push_back(i == m.size() - 1);
      end
      p = m;
      p.push_back(8'h80);
      while (p.size() % bb != bb - lb) p.push_back(8'h00);
      for (int k = lb - 1; k >= 0; k--) p.push_back(k < 8 ? 8'(bits >> (8 * k)) : 8'h00);
      nw = p.size() / wb;
      for (int i = 0; i < nw; i++) begin
         w = '0;
         for (int j = 0; j < wb; j++) w = (w << 8) | 64'(p[i * wb + j]);
         exp_words.push_back(w);
         exp_idx.push_back(4'(i % 16));
         exp_last.push_back(i == nw - 1);
      end
      pad_total += p.size();
   endtask

   task automatic run(input bit rand_ready, input bit rand_valid, input bit timing_check);
      int          wb = sel ? 8 : 4;
      int          bi = 0, wi = 0, acc = 0, cyc = 0, first_cyc = -1;
      bit          padding = 0, stalled = 0;
      logic [63:0] pd;
      logic        pf, pl;
      logic [3:0]  pidx;
      while (wi < exp_words.size() && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bi < q_bytes.size()) begin
            byte_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            byte_data  = q_bytes[bi];
            byte_last  = q_last[bi];
         end else begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom_range(0, 255));
            byte_last  = 1'b0;
         end
         #1;
         if (stalled) begin
            checks++;
            if (word_valid_o !== 1'b1 || word_data_o !== pd || word_first_o !== pf ||
                word_last_o !== pl || word_idx_o !== pidx)
               $display("FAIL stall_hold: got v=%b d=%h f=%b l=%b i=%0d want v=1 d=%h f=%b l=%b i=%0d",
                        word_valid_o, word_data_o, word_first_o, word_last_o, word_idx_o, pd, pf, pl, pidx);
            if (word_valid_o !== 1'b1 || word_data_o !== pd || word_first_o !== pf ||
                word_last_o !== pl || word_idx_o !== pidx) failures++;
         end
         if (padding && !(word_valid_o && word_last_o)) begin
            checks++;
            if (byte_ready_o !== 1'b0) begin
               failures++;
               $display("FAIL ready_in_padding: byte_ready=%b want 0", byte_ready_o);
            end
         end
         if (!padding && word_valid_o && !word_ready && (acc % wb) == wb - 1) begin
            checks++;
            if (byte_ready_o !== 1'b0) begin
               failures++;
               $display("FAIL ready_when_full: byte_ready=%b want 0 (acc=%0d)", byte_ready_o, acc);
            end
         end
         if (word_valid_o && word_ready) begin
            checks++;
            if (word_data_o !== exp_words[wi] || word_idx_o !== exp_idx[wi] ||
                word_first_o !== (exp_idx[wi] == 4'd0) || word_last_o !== exp_last[wi]) begin
               failures++;
               $display("FAIL word%0d: got d=%h i=%0d f=%b l=%b want d=%h i=%0d f=%b l=%b", wi,
                        word_data_o, word_idx_o, word_first_o, word_last_o,
                        exp_words[wi], exp_idx[wi], exp_idx[wi] == 4'd0, exp_last[wi]);
            end
            if (timing_check && wi == exp_words.size() - 1) begin
               checks++;
               if (cyc - first_cyc != pad_total) begin
                  failures++;
                  $display("FAIL latency: got %0d cycles want %0d", cyc - first_cyc, pad_total);
               end
            end
            wi++;
         end
         stalled = word_valid_o && !word_ready;
         pd = word_data_o; pf = word_first_o; pl = word_last_o; pidx = word_idx_o;
         if (word_valid_o && word_last_o) padding = 0;
         if (byte_valid && byte_ready_o) begin
            if (first_cyc < 0) first_cyc = cyc;
            acc++;
            bi++;
            if (byte_last) begin
               padding = 1;
               acc = 0;
            end
         end
      end
      checks++;
      if (wi != exp_words.size() || bi != q_bytes.size()) begin
         failures++;
         $display("FAIL timeout: words=%0d want %0d bytes=%0d want %0d", wi, exp_words.size(), bi, q_bytes.size());
      end
      @(negedge clk);
      byte_valid = 1'b0;
      word_ready = 1'b1;
      #1;
      checks++;
      if (word_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL extra_word: word_valid=%b want 0", word_valid_o);
      end
      q_bytes.delete(); q_last.delete();
      exp_words.delete(); exp_idx.delete(); exp_last.delete();
      pad_total = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      byte_valid = 1'b0;
      word_ready = 1'b1;
      #1;
      checks++;
      if (byte_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_low: byte_ready=%b want 0", byte_ready_o);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (byte_ready_o !== 1'b1 || word_valid_o !== 1'b0 || word_data_o !== 64'h0 ||
          word_first_o !== 1'b0 || word_idx_o !== 4'd0 || word_last_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: br=%b v=%b d=%h f=%b i=%0d l=%b want br=1 v=0 d=0 f=0 i=0 l=0",
                  byte_ready_o, word_valid_o, word_data_o, word_first_o, word_idx_o, word_last_o);
      end
   endtask

   function automatic void fill_const(output logic [7:0] m[$], input int n, input logic [7:0] v);
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(v);
   endfunction

   function automatic void fill_rand(output logic [7:0] m[$], input int n);
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
   endfunction

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      sel = 1'b1;
      #1;
      checks++;
      if (byte_ready_o !== 1'b1 || word_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_values_512: br=%b v=%b want br=1 v=0", byte_ready_o, word_valid_o);
      end
   endtask

   task automatic test_abc(input bit wide);
      logic [7:0] m[$];
      sel = wide;
      m = '{8'h61, 8'h62, 8'h63};
      add_msg(m);
      run(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_boundary();
      logic [7:0] m[$];
      sel = 1'b0;
      fill_const(m, 55, 8'h61);
      add_msg(m);
      run(1'b0, 1'b0, 1'b1);
      fill_const(m, 56, 8'h61);
      add_msg(m);
      run(1'b0, 1'b0, 1'b1);
      sel = 1'b1;
      fill_const(m, 111, 8'h61);
      add_msg(m);
      run(1'b0, 1'b0, 1'b1);
      fill_const(m, 112, 8'h61);
      add_msg(m);
      run(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [7:0] m[$];
      m = '{8'h61, 8'h62, 8'h63};
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         add_msg(m);
         run(1'b1, 1'b0, 1'b0);
         add_msg(m);
         run(1'b1, 1'b1, 1'b0);
      end
   endtask

   task automatic test_abort();
      logic [7:0] m[$];
      int         acc = 0, cyc = 0;
      sel = 1'b0;
      while (acc < 20 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         byte_valid = 1'b1;
         byte_data  = 8'($urandom_range(0, 255));
         byte_last  = 1'b0;
         word_ready = 1'b1;
         #1;
         if (byte_ready_o) acc++;
      end
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (word_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_words: word_valid=%b want 0", word_valid_o);
         end
      end
      m = '{8'h61, 8'h62, 8'h63};
      add_msg(m);
      run(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] m[$];
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int k = 0; k < 3; k++) begin
            fill_rand(m, $urandom_range(1, 40));
            add_msg(m);
         end
         run(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_random();
      logic [7:0] m[$];
      for (int t = 0; t < 8; t++) begin
         sel = t[0];
         fill_rand(m, $urandom_range(1, 150));
         add_msg(m);
         fill_rand(m, $urandom_range(1, 20));
         add_msg(m);
         run(1'b1, 1'b1, 1'b0);
      end
   endtask

   initial begin
      rst        = 1'b1;
      sel        = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      byte_last  = 1'b0;
      word_ready = 1'b1;
      pad_total  = 0;
      test_reset();
      test_abc(1'b0);
      test_abc(1'b1);
      test_boundary();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
